// File: rtl/mio_bus_pkg.sv
// rtl/mio_bus_pkg.sv - address map, TCTRL bit positions and timer state encoding for mio_bus_ctrl
package mio_bus_pkg;

  localparam logic [31:0] SEG_ADDR   = 32'hE000_0000;
  localparam logic [31:0] GPIO_ADDR  = 32'hF000_0000;
  localparam logic [31:0] TCNT_ADDR  = 32'hF000_0004;
  localparam logic [31:0] TCTRL_ADDR = 32'hF000_0008;

  localparam int TCTRL_EN       = 0;
  localparam int TCTRL_PERIODIC = 1;
  localparam int TCTRL_PEND     = 2;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_RUN  = 2'd1,
    T_DONE = 2'd2
  } timer_state_e;

endpackage

// File: rtl/mio_bus_if.sv
// rtl/mio_bus_if.sv - core-side load/store bus between the MIPS core and mio_bus_ctrl
interface mio_bus_if;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;

  modport master (output cpu_we, output cpu_addr, output cpu_wdata, input  cpu_rdata);
  modport slave  (input  cpu_we, input  cpu_addr, input  cpu_wdata, output cpu_rdata);
endinterface

// File: rtl/mio_bus_ctrl_timer.sv
// rtl/mio_bus_ctrl_timer.sv - interval timer: prescaler, down-counter, IDLE/RUN/DONE FSM, IRQ_PEND
module mio_timer
  import mio_bus_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tcnt_we_i,
  input  logic             tctrl_we_i,
  input  logic [31:0]      wdata_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [2:0]       ctrl_o
);

  localparam int             PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PLAST = PW'(PRESCALE - 1);

  timer_state_e     state_q;
  logic [PW-1:0]    presc_q;
  logic [CNT_W-1:0] cnt_q, reload_q;
  logic             en_q, per_q, pend_q;
  logic [CNT_W-1:0] load_val;
  logic             tick;

  assign load_val = CNT_W'(wdata_i);
  assign tick     = (presc_q == PLAST);
  assign cnt_o    = cnt_q;
  assign ctrl_o   = {pend_q, per_q, en_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= T_IDLE;
      presc_q  <= '0;
      cnt_q    <= '0;
      reload_q <= '0;
      en_q     <= 1'b0;
      per_q    <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      if (tctrl_we_i) begin
        en_q  <= wdata_i[TCTRL_EN];
        per_q <= wdata_i[TCTRL_PERIODIC];
        if (wdata_i[TCTRL_PEND]) pend_q <= 1'b0;
      end
      case (state_q)
        T_IDLE: begin
          presc_q <= '0;
          if (tcnt_we_i) begin
            cnt_q    <= load_val;
            reload_q <= load_val;
          end
          if (tctrl_we_i && wdata_i[TCTRL_EN]) state_q <= T_RUN;
        end
        T_RUN: begin
          if (tctrl_we_i && !wdata_i[TCTRL_EN]) begin
            state_q <= T_IDLE;
            presc_q <= '0;
          end else if (tcnt_we_i) begin
            cnt_q    <= load_val;
            reload_q <= load_val;
            presc_q  <= '0;
          end else begin
            presc_q <= tick ? '0 : presc_q + PW'(1);
            if (tick) begin
              // A counter of 0 or 1 expires on this tick; the set overrides a same-cycle W1C.
              if (cnt_q <= CNT_W'(1)) begin
                pend_q <= 1'b1;
                if (per_q) begin
                  cnt_q <= reload_q;
                end else begin
                  cnt_q   <= '0;
                  state_q <= T_DONE;
                end
              end else begin
                cnt_q <= cnt_q - CNT_W'(1);
              end
            end
          end
        end
        T_DONE: begin
          presc_q <= '0;
          if (tctrl_we_i && !wdata_i[TCTRL_EN]) begin
            state_q <= T_IDLE;
          end else if (tcnt_we_i) begin
            cnt_q    <= load_val;
            reload_q <= load_val;
            if (en_q) state_q <= T_RUN;
          end
        end
        default: state_q <= T_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mio_bus_ctrl.sv
// rtl/mio_bus_ctrl.sv - MIPS memory/IO bus decode, GPIO/SEG registers and read mux; MIO_TIMER_IRQ_EN drives int_o from IRQ_PEND
module mio_bus_ctrl
  import mio_bus_pkg::*;
#(
  parameter int RAM_AW   = 10,
  parameter int CNT_W    = 32,
  parameter int PRESCALE = 4
) (
  input  logic              clk,
  input  logic              reset,
  mio_bus_if.slave          bus,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic [15:0]       sw_in,
  output logic [15:0]       led_out,
  output logic [31:0]       seg_out,
  output logic              int_o
);

  logic [15:0]      led_q;
  logic [31:0]      seg_q;
  logic             ram_hit, seg_hit, gpio_hit, tcnt_hit, tctrl_hit;
  logic [CNT_W-1:0] tmr_cnt;
  logic [2:0]       tmr_ctrl;
  logic             unused_byte_lane;

  // Word accesses only: the byte-lane bits take no part in decode.
  assign unused_byte_lane = ^bus.cpu_addr[1:0];
  assign ram_hit   = (bus.cpu_addr[31:28] == 4'h0);
  assign seg_hit   = (bus.cpu_addr[31:2] == SEG_ADDR[31:2]);
  assign gpio_hit  = (bus.cpu_addr[31:2] == GPIO_ADDR[31:2]);
  assign tcnt_hit  = (bus.cpu_addr[31:2] == TCNT_ADDR[31:2]);
  assign tctrl_hit = (bus.cpu_addr[31:2] == TCTRL_ADDR[31:2]);

  assign ram_we    = bus.cpu_we & ram_hit;
  assign ram_addr  = bus.cpu_addr[RAM_AW+1:2];
  assign ram_wdata = bus.cpu_wdata;
  assign led_out   = led_q;
  assign seg_out   = seg_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q <= '0;
      seg_q <= '0;
    end else if (bus.cpu_we) begin
      if (gpio_hit) led_q <= bus.cpu_wdata[15:0];
      if (seg_hit)  seg_q <= bus.cpu_wdata;
    end
  end

  mio_timer #(
    .CNT_W    (CNT_W),
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .tcnt_we_i  (bus.cpu_we & tcnt_hit),
    .tctrl_we_i (bus.cpu_we & tctrl_hit),
    .wdata_i    (bus.cpu_wdata),
    .cnt_o      (tmr_cnt),
    .ctrl_o     (tmr_ctrl)
  );

  always_comb begin
    bus.cpu_rdata = 32'h0;
    if (ram_hit)        bus.cpu_rdata = ram_rdata;
    else if (seg_hit)   bus.cpu_rdata = seg_q;
    else if (gpio_hit)  bus.cpu_rdata = {16'h0, sw_in};
    else if (tcnt_hit)  bus.cpu_rdata = 32'(tmr_cnt);
    else if (tctrl_hit) bus.cpu_rdata = {29'h0, tmr_ctrl};
  end

`ifdef MIO_TIMER_IRQ_EN
  assign int_o = tmr_ctrl[TCTRL_PEND];
`else
  assign int_o = 1'b0;
`endif

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// tb/tb_mio_bus_ctrl.sv - randomized self-checking bench for mio_bus_ctrl against a tick-arithmetic timer model
module tb_mio_bus_ctrl;
  localparam int P = 4;
`ifdef MIO_TIMER_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic [15:0] sw_in, led_out;
  logic [31:0] seg_out;
  logic        int_o;
  int          checks = 0;
  int          errors = 0;

  mio_bus_if bus ();

  mio_bus_ctrl #(.RAM_AW(10), .CNT_W(32), .PRESCALE(P)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .sw_in(sw_in), .led_out(led_out), .seg_out(seg_out), .int_o(int_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called near a falling edge; returns at the falling edge after the write commits.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.cpu_we = 1'b1; bus.cpu_addr = a; bus.cpu_wdata = d;
    @(posedge clk);
    @(negedge clk);
    bus.cpu_we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.cpu_we = 1'b0; bus.cpu_addr = a;
    #1;
    d = bus.cpu_rdata;
  endtask

  // Timer model: k edges after a load/start, ticks = k / P.
  function automatic int unsigned oneshot_cnt(int unsigned n, int unsigned k);
    int unsigned t = k / P;
    return (t >= n) ? 0 : n - t;
  endfunction

  function automatic int unsigned periodic_cnt(int unsigned n, int unsigned k);
    int unsigned t = k / P;
    return (t < n) ? n - t : n - ((t - n) % n);
  endfunction

  task automatic run_check(input string tag, input bit periodic, input int unsigned n, input int unsigned kmax);
    logic [31:0] v;
    bit pend;
    for (int k = 0; k <= int'(kmax); k++) begin
      if (k > 0) @(negedge clk);
      pend = (k / P) >= ((n == 0) ? 1 : n);
      rd(32'hF000_0004, v);
      chk({tag, "_cnt"}, v, periodic ? periodic_cnt(n, k) : oneshot_cnt(n, k));
      rd(32'hF000_0008, v);
      chk({tag, "_ctrl"}, v, {29'h0, pend, periodic, 1'b1});
      chk({tag, "_int"}, {31'h0, int_o}, {31'h0, IRQ_ON & pend});
    end
  endtask

  initial begin
    logic [31:0] a, d, v;
    int unsigned n;
    bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0; bus.cpu_wdata = 32'h0;
    ram_rdata = 32'h0; sw_in = 16'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    chk("rst_led", {16'h0, led_out}, 32'h0);
    chk("rst_seg", seg_out, 32'h0);
    chk("rst_int", {31'h0, int_o}, 32'h0);
    rd(32'hF000_0004, v); chk("rst_tcnt", v, 32'h0);
    rd(32'hF000_0008, v); chk("rst_tctrl", v, 32'h0);

    // RAM path
    bus.cpu_we = 1'b1; bus.cpu_addr = 32'h0000_0010; bus.cpu_wdata = 32'h1234_5678; #1;
    chk("ram_we", {31'h0, ram_we}, 32'h1);
    chk("ram_addr", {22'h0, ram_addr}, 32'h4);
    chk("ram_wdata", ram_wdata, 32'h1234_5678);
    for (int i = 0; i < 6; i++) begin
      a = {4'h0, 28'($urandom)}; d = $urandom;
      bus.cpu_we = 1'b1; bus.cpu_addr = a; bus.cpu_wdata = d; #1;
      chk("ram_we_r", {31'h0, ram_we}, 32'h1);
      chk("ram_addr_r", {22'h0, ram_addr}, {22'h0, a[11:2]});
      ram_rdata = $urandom;
      rd(a, v); chk("ram_rd", v, ram_rdata);
    end
    bus.cpu_we = 1'b1; bus.cpu_addr = 32'hF000_0000; #1;
    chk("ram_we_io", {31'h0, ram_we}, 32'h0);
    bus.cpu_we = 1'b0;
    @(negedge clk);

    // GPIO, SEG, unmapped
    wr(32'hF000_0000, 32'h0001_A5A5);
    chk("led", {16'h0, led_out}, 32'h0000_A5A5);
    sw_in = 16'h00FF; rd(32'hF000_0000, v); chk("sw", v, 32'h0000_00FF);
    for (int i = 0; i < 4; i++) begin
      sw_in = 16'($urandom); rd(32'hF000_0000, v); chk("sw_r", v, {16'h0, sw_in});
    end
    rd(32'hF000_0010, v); chk("unmap_f10", v, 32'h0);
    rd(32'h1000_0000, v); chk("unmap_1", v, 32'h0);
    d = $urandom;
    wr(32'hE000_0002, d);
    chk("seg", seg_out, d);
    rd(32'hE000_0000, v); chk("seg_rd", v, d);
    wr(32'hF000_000C, 32'hFFFF_FFFF);
    wr(32'hE000_0004, 32'hFFFF_FFFF);
    chk("unmap_led", {16'h0, led_out}, 32'h0000_A5A5);
    chk("unmap_seg", seg_out, d);

    // One-shot, the reference case first, then random lengths including 0
    for (int i = 0; i < 3; i++) begin
      n = (i == 0) ? 3 : $urandom_range(0, 5);
      wr(32'hF000_0008, 32'h4);
      wr(32'hF000_0004, n);
      wr(32'hF000_0008, 32'h1);
      run_check("oneshot", 1'b0, n, P * ((n == 0) ? 1 : n) + 3);
      chk("fsm_done", 32'(dut.u_timer.state_q), 32'd2);
    end

    // DONE -> RUN via TCNT write
    wr(32'hF000_0008, 32'h5);
    rd(32'hF000_0008, v); chk("w1c_done", v, 32'h1);
    wr(32'hF000_0004, 32'd2);
    run_check("done_rerun", 1'b0, 2, 2 * P + 2);

    // Periodic, random reload
    for (int i = 0; i < 2; i++) begin
      n = $urandom_range(1, 4);
      wr(32'hF000_0008, 32'h4);
      wr(32'hF000_0004, n);
      wr(32'hF000_0008, 32'h3);
      run_check("periodic", 1'b1, n, 3 * P * n + 1);
    end

    // Periodic 2: W1C on the expiry edge keeps PEND, W1C elsewhere clears it
    wr(32'hF000_0008, 32'h4);
    wr(32'hF000_0004, 32'd2);
    wr(32'hF000_0008, 32'h3);
    run_check("per2", 1'b1, 2, 15);
    wr(32'hF000_0008, 32'h7);
    rd(32'hF000_0008, v); chk("w1c_collide", v, 32'h7);
    rd(32'hF000_0004, v); chk("reload_cnt", v, 32'd2);
    @(negedge clk);
    wr(32'hF000_0008, 32'h7);
    rd(32'hF000_0008, v); chk("w1c_clear", v, 32'h3);
    repeat (5) @(negedge clk);
    rd(32'hF000_0008, v); chk("per_pre", v, 32'h3);
    @(negedge clk);
    rd(32'hF000_0008, v); chk("per_again", v, 32'h7);

    // TCNT write while running clears the prescaler
    wr(32'hF000_0008, 32'h4);
    wr(32'hF000_0004, 32'd5);
    wr(32'hF000_0008, 32'h1);
    repeat (6) @(negedge clk);
    wr(32'hF000_0004, 32'd2);
    run_check("reload_run", 1'b0, 2, 2 * P + 2);

    // EN=0 mid-count holds the counter, EN=1 resumes from it
    wr(32'hF000_0008, 32'h5);
    wr(32'hF000_0004, 32'd5);
    repeat (5) @(negedge clk);
    wr(32'hF000_0008, 32'h0);
    repeat (10) @(negedge clk);
    rd(32'hF000_0004, v); chk("hold_cnt", v, 32'd4);
    rd(32'hF000_0008, v); chk("hold_ctrl", v, 32'h0);
    wr(32'hF000_0008, 32'h1);
    run_check("resume", 1'b0, 4, 4 * P + 1);

    // Asynchronous reset mid-run
    wr(32'hF000_0004, 32'd7);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("arst_led", {16'h0, led_out}, 32'h0);
    chk("arst_seg", seg_out, 32'h0);
    chk("arst_int", {31'h0, int_o}, 32'h0);
    rd(32'hF000_0004, v); chk("arst_tcnt", v, 32'h0);
    rd(32'hF000_0008, v); chk("arst_tctrl", v, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    rd(32'hF000_0004, v); chk("post_rst_cnt", v, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
